// File: rtl/adc_serial_responder.sv
// Responder end of a cs/sclk/sdata serial-ADC link: parallel samples arrive on a
// valid/ready port and are shifted out MSB-first in a zero-padded frame per cs-low.
module adc_serial_responder #(
  parameter int DATA_W  = 12,
  parameter int FRAME_W = 16,
  parameter bit SYNC_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sclk,
  output logic              sdata,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              underrun
);

  localparam int CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  logic               cs_now;
  logic               sclk_now;
  logic               cs_q;
  logic               sclk_q;
  logic               cs_fall;
  logic               cs_rise;
  logic               sclk_rise;
  logic [DATA_W-1:0]  pending;
  logic               pending_full;
  logic [DATA_W-1:0]  last;
  logic [DATA_W-1:0]  frame_src;
  logic [FRAME_W-1:0] frame_word;
  logic [FRAME_W-1:0] frame_reg;
  logic [CNT_W-1:0]   count;

  // Optional two-flop synchronizers; reset loads the live pin level so that
  // releasing reset never manufactures an edge.
  if (SYNC_EN) begin : g_sync
    logic [1:0] cs_meta;
    logic [1:0] sclk_meta;

    always_ff @(posedge clk) begin
      if (rst) begin
        cs_meta   <= {2{cs}};
        sclk_meta <= {2{sclk}};
      end else begin
        cs_meta   <= {cs_meta[0], cs};
        sclk_meta <= {sclk_meta[0], sclk};
      end
    end

    assign cs_now   = cs_meta[1];
    assign sclk_now = sclk_meta[1];
  end else begin : g_direct
    assign cs_now   = cs;
    assign sclk_now = sclk;
  end

  assign cs_fall   = cs_q & ~cs_now;
  assign cs_rise   = ~cs_q & cs_now;
  assign sclk_rise = ~sclk_q & sclk_now;

  assign sample_ready = ~pending_full;

  // A frame carries the fresh sample if one is waiting, otherwise it repeats the last one.
  assign frame_src  = pending_full ? pending : last;
  assign frame_word = FRAME_W'(frame_src);

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the same pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sdata        <= 1'b0;
      frame_done   <= 1'b0;
      frame_abort  <= 1'b0;
      underrun     <= 1'b0;
      count        <= '0;
      frame_reg    <= '0;
      cs_q         <= cs;
      sclk_q       <= sclk;
      // NOTE: the sample registers are reset too, because an underrun right after
      // reset must transmit a defined all-zero frame rather than stale data.
      pending      <= '0;
      pending_full <= 1'b0;
      last         <= '0;
    end else begin
      cs_q        <= cs_now;
      sclk_q      <= sclk_now;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;

      if (sample_valid && sample_ready) begin
        pending      <= sample_in;
        pending_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          sdata <= 1'b0;
          if (cs_fall) begin
            frame_reg <= frame_word;
            sdata     <= frame_word[FRAME_W-1];
            count     <= CNT_W'(FRAME_W - 1);
            state     <= SHIFT;
            if (pending_full) begin
              last         <= pending;
              pending_full <= 1'b0;
            end else begin
              underrun <= 1'b1;
            end
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            frame_abort <= 1'b1;
            sdata       <= 1'b0;
            state       <= IDLE;
          end else if (sclk_rise) begin
            if (count == '0) begin
              frame_done <= 1'b1;
              sdata      <= 1'b0;
              state      <= DONE;
            end else begin
              count <= count - 1'b1;
              sdata <= frame_reg[count - 1'b1];
            end
          end
        end

        DONE: begin
          sdata <= 1'b0;
          if (cs_rise) begin
            state <= IDLE;
          end
        end

        default: begin
          sdata <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_responder.sv
// Randomized scoreboard bench for adc_serial_responder: a reader model drives cs/sclk,
// a monitor rebuilds each frame from sdata and compares it with the queued expectation.
module tb_adc_serial_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        sclk;
  logic        sdata;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        frame_done;
  logic        frame_abort;
  logic        underrun;

  adc_serial_responder #(
    .DATA_W (12),
    .FRAME_W(16),
    .SYNC_EN(1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cs          (cs),
    .sclk        (sclk),
    .sdata       (sdata),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          abort;
    int          n;
    logic [15:0] bits;
    int          ur;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model of the sample store: at most one waiting sample plus the last sent.
  bit          m_pend_full = 1'b0;
  logic [11:0] m_pend      = '0;
  logic [11:0] m_last      = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Monitor: rebuilds frames from what the reader would see and scores them.
  logic        mon_cs_prev   = 1'b1;
  logic        mon_sclk_prev = 1'b0;
  bit          collecting    = 1'b0;
  int          mon_n         = 0;
  int          mon_ur        = 0;
  logic [15:0] mon_bits      = '0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst) begin
      collecting = 1'b0;
      mon_n      = 0;
      mon_ur     = 0;
      mon_bits   = '0;
    end else begin
      if (mon_cs_prev && !cs) begin
        collecting = 1'b1;
        mon_n      = 0;
        mon_ur     = 0;
        mon_bits   = '0;
      end
      if (collecting && !cs && sclk && !mon_sclk_prev) begin
        mon_bits = {mon_bits[14:0], sdata};
        mon_n++;
      end
      if (underrun) begin
        if (collecting) mon_ur++;
        else check("stray_underrun", 32'(underrun), 0);
      end
      if (frame_done || frame_abort) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame_pulse", 32'({frame_done, frame_abort}), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("frame_kind", 32'({frame_done, frame_abort}), mon_e.abort ? 32'd1 : 32'd2);
          check("frame_bit_count", 32'(mon_n), 32'(mon_e.n));
          check("frame_data", 32'(mon_bits), 32'(mon_e.bits));
          check("frame_underrun", 32'(mon_ur), 32'(mon_e.ur));
          check("sdata_after_frame", 32'(sdata), 0);
        end
        collecting = 1'b0;
      end
    end
    mon_cs_prev   = cs;
    mon_sclk_prev = sclk;
  end

  task automatic load(input logic [11:0] v);
    check("ready_before_load", 32'(sample_ready), 32'(!m_pend_full));
    sample_valid = 1'b1;
    sample_in    = v;
    tick(1);
    sample_valid = 1'b0;
    if (!m_pend_full) begin
      m_pend      = v;
      m_pend_full = 1'b1;
    end
  endtask

  // One cs-low period with 'rises' sclk rises; fewer than 16 ends in an abort.
  task automatic run_frame(input int half, input int rises, input bit load_same,
                           input logic [11:0] val);
    exp_t        e;
    logic [11:0] word;
    bit          pend_before;
    pend_before = m_pend_full;
    if (m_pend_full) begin
      word        = m_pend;
      m_last      = m_pend;
      m_pend_full = 1'b0;
      e.ur        = 0;
    end else begin
      word = m_last;
      e.ur = 1;
    end
    if (load_same && !pend_before) begin
      m_pend      = val;
      m_pend_full = 1'b1;
    end
    e.abort = (rises < 16);
    e.n     = rises;
    e.bits  = {4'b0000, word} >> (16 - rises);
    exp_q.push_back(e);

    cs = 1'b0;
    if (load_same) begin
      sample_valid = 1'b1;
      sample_in    = val;
    end
    tick(1);
    sample_valid = 1'b0;
    tick(1);
    check("ready_after_cs_fall", 32'(sample_ready), 32'(!m_pend_full));
    if (half > 2) tick(half - 2);
    for (int i = 0; i < rises; i++) begin
      sclk = 1'b1;
      tick(half);
      sclk = 1'b0;
      tick(half);
    end
    cs = 1'b1;
    tick(half + 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d frames outstanding", exp_q.size());
    $fatal(1);
  end

  initial begin
    int pulses;
    int half;
    int rises;
    bit same;

    rst          = 1'b1;
    cs           = 1'b1;
    sclk         = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    tick(1);
    for (int i = 0; i < 6; i++) begin
      sclk = ~sclk;
      tick(1);
    end
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      sclk = ~sclk;
      tick(1);
      pulses += int'(frame_done) + int'(frame_abort) + int'(underrun);
      if (i == 0 || i == 19) begin
        check("reset_sdata", 32'(sdata), 0);
        check("reset_ready", 32'(sample_ready), 1);
      end
    end
    check("reset_no_pulses", 32'(pulses), 0);

    load(12'h800);
    run_frame(5, 16, 1'b0, '0);

    load(12'hABC);
    run_frame(5, 16, 1'b0, '0);
    load(12'h123);
    run_frame(4, 16, 1'b0, '0);

    load(12'h5A5);
    run_frame(3, 16, 1'b0, '0);
    run_frame(3, 16, 1'b0, '0);

    load(12'h0F0);
    run_frame(5, 7, 1'b0, '0);
    load(12'hFFF);
    run_frame(5, 16, 1'b0, '0);

    // Load coinciding with cs fall while empty: repeats last, new sample waits.
    run_frame(2, 16, 1'b1, 12'h456);
    run_frame(2, 16, 1'b0, '0);

    // Reset in the middle of a frame with cs still low across the release.
    load(12'h3C3);
    cs = 1'b0;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b1;
      tick(3);
      sclk = 1'b0;
      tick(3);
    end
    rst = 1'b1;
    tick(1);
    check("midreset_sdata", 32'(sdata), 0);
    check("midreset_ready", 32'(sample_ready), 1);
    check("midreset_pulses", 32'({frame_done, frame_abort, underrun}), 0);
    rst         = 1'b0;
    m_pend_full = 1'b0;
    m_pend      = '0;
    m_last      = '0;
    pulses      = 0;
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b1;
      tick(3);
      pulses += int'(frame_done) + int'(frame_abort) + int'(underrun);
      sclk = 1'b0;
      tick(3);
      pulses += int'(frame_done) + int'(frame_abort) + int'(underrun);
    end
    cs = 1'b1;
    tick(5);
    check("stale_cs_ignored", 32'(pulses + int'(sdata)), 0);
    load(12'h001);
    run_frame(4, 16, 1'b0, '0);

    for (int k = 0; k < 25; k++) begin
      half  = $urandom_range(2, 6);
      rises = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 16;
      same  = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) != 0) load(12'($urandom));
      if ($urandom_range(0, 3) == 0) load(12'($urandom));
      run_frame(half, rises, same, 12'($urandom));
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
